sync_downcount: RTL and testbench



---
 rtl/sync_downcount_if.sv | 26 ++
 rtl/sync_downcount.sv | 103 ++++++++++
 tb/tb_sync_downcount.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sync_downcount_if.sv
// Control/status bundle for sync_downcount: the controller drives load/en/mode,
// the counter returns its count, busy flag, terminal-count pulse and FSM state.
interface sync_downcount_if #(
    parameter int WIDTH = 4
);
    // No handshake: load, load_val, en and mode are level inputs sampled on every
    // rising clk edge; q, busy, tc and fsm_state are registered and valid after it.
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             tc;
    logic             fsm_state;

    modport master (
        output load, load_val, en, mode,
        input  q, busy, tc, fsm_state
    );

    modport slave (
        input  load, load_val, en, mode,
        output q, busy, tc, fsm_state
    );
endinterface

// File: rtl/sync_downcount.sv
// Loadable synchronous down-counter with one-cycle terminal-count pulse and
// optional auto-reload; optional tick prescaler enabled by DOWNCOUNT_PRESCALE_EN.
module sync_downcount #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst,
    sync_downcount_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    if (WIDTH < 2 || PRESCALE < 2) begin : g_bad_param
        $error("sync_downcount: WIDTH and PRESCALE must both be >= 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             tick;

`ifdef DOWNCOUNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          advance;

    // Prescaler only moves on enabled RUN edges; it freezes while paused.
    always_comb begin
        advance = (state_q == RUN) && bus.en;
        tick    = advance && (pre_q == PRE_LAST);
        pre_d   = pre_q;
        if (bus.load) begin
            pre_d = '0;
        end else if (advance) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    always_comb begin
        tick = (state_q == RUN) && bus.en;
    end
`endif

    // Load beats everything, including a coincident terminal tick.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            q_d     = bus.load_val;
            rld_d   = bus.load_val;
            state_d = (bus.load_val != '0) ? RUN : IDLE;
        end else if (tick) begin
            if (q_q > WIDTH'(1)) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (bus.mode) begin
                    q_d = rld_q;
                end else begin
                    q_d     = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.tc        = tc_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_sync_downcount.sv
// Directed self-checking bench for sync_downcount: reset, one-shot, auto-reload,
// pause, load priority and prescaler timing with hand-computed expectations.
module tb_sync_downcount;

`ifdef DOWNCOUNT_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    sync_downcount_if #(.WIDTH(4)) bus ();

    sync_downcount #(
        .WIDTH    (4),
        .PRESCALE (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: advance one edge and settle, or advance n counter ticks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n * P) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] eq, input logic eb, input logic et);
        check({tag, ".q"},    {28'd0, bus.q},    {28'd0, eq});
        check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, eb});
        check({tag, ".tc"},   {31'd0, bus.tc},   {31'd0, et});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        bus.en       = 1'b0;
        bus.mode     = 1'b0;

        #3;
        check_out("reset", 4'd0, 1'b0, 1'b0);
        check("reset.state", {31'd0, bus.fsm_state}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check_out("post_reset_idle", 4'd0, 1'b0, 1'b0);

        // One-shot: load 5
        bus.load = 1'b1; bus.load_val = 4'd5; bus.mode = 1'b0; bus.en = 1'b1;
        step();
        bus.load = 1'b0;
        check_out("os_load", 4'd5, 1'b1, 1'b0);
        check("os_load.state", {31'd0, bus.fsm_state}, 32'd1);
        ticks(1); check_out("os_4", 4'd4, 1'b1, 1'b0);
        ticks(1); check_out("os_3", 4'd3, 1'b1, 1'b0);
        ticks(1); check_out("os_2", 4'd2, 1'b1, 1'b0);
        ticks(1); check_out("os_1", 4'd1, 1'b1, 1'b0);
        ticks(1); check_out("os_tc", 4'd0, 1'b0, 1'b1);
        step();   check_out("os_after", 4'd0, 1'b0, 1'b0);
        bus.mode = 1'b1;
        step();   check_out("idle_ignores_en_mode", 4'd0, 1'b0, 1'b0);

        // Auto-reload: load 3, then switch to one-shot mid-period
        bus.load = 1'b1; bus.load_val = 4'd3; bus.mode = 1'b1;
        step();
        bus.load = 1'b0;
        check_out("ar_load", 4'd3, 1'b1, 1'b0);
        ticks(1); check_out("ar_2", 4'd2, 1'b1, 1'b0);
        ticks(1); check_out("ar_1", 4'd1, 1'b1, 1'b0);
        ticks(1); check_out("ar_reload", 4'd3, 1'b1, 1'b1);
        ticks(1); check_out("ar_2b", 4'd2, 1'b1, 1'b0);
        bus.mode = 1'b0;
        ticks(1); check_out("ar_1b", 4'd1, 1'b1, 1'b0);
        ticks(1); check_out("ar_stop", 4'd0, 1'b0, 1'b1);

        // Auto-reload with rld==1: tc on every tick
        bus.load = 1'b1; bus.load_val = 4'd1; bus.mode = 1'b1;
        step();
        bus.load = 1'b0;
        check_out("rld1_load", 4'd1, 1'b1, 1'b0);
        ticks(1); check_out("rld1_t1", 4'd1, 1'b1, 1'b1);
        ticks(1); check_out("rld1_t2", 4'd1, 1'b1, 1'b1);

        // Pause: en low holds q
        bus.load = 1'b1; bus.load_val = 4'd9; bus.mode = 1'b0;
        step();
        bus.load = 1'b0;
        check_out("pause_load", 4'd9, 1'b1, 1'b0);
        ticks(1); check_out("pause_8", 4'd8, 1'b1, 1'b0);
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("pause_hold", 4'd8, 1'b1, 1'b0);
        end
        bus.en = 1'b1;
        ticks(1); check_out("pause_resume", 4'd7, 1'b1, 1'b0);

        // Load coincident with the terminal tick wins
        ticks(6); check_out("prio_at_1", 4'd1, 1'b1, 1'b0);
        repeat (P - 1) step();
        bus.load = 1'b1; bus.load_val = 4'd7;
        step();
        bus.load = 1'b0;
        check_out("prio_load7", 4'd7, 1'b1, 1'b0);
        ticks(1); check_out("prio_6", 4'd6, 1'b1, 1'b0);

        // Load of zero goes idle without a pulse
        bus.load = 1'b1; bus.load_val = 4'd0;
        step();
        bus.load = 1'b0;
        check_out("load0", 4'd0, 1'b0, 1'b0);
        bus.mode = 1'b1;
        ticks(1); check_out("load0_idle", 4'd0, 1'b0, 1'b0);

        // Reset mid-count, asserted between edges
        bus.load = 1'b1; bus.load_val = 4'd9; bus.mode = 1'b0;
        step();
        bus.load = 1'b0;
        ticks(3); check_out("rst_mid_pre", 4'd6, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_out("rst_mid_async", 4'd0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        check_out("rst_mid_after", 4'd0, 1'b0, 1'b0);
        step();
        check_out("rst_mid_quiet", 4'd0, 1'b0, 1'b0);

        // Tick timing: load 2, one-shot
        bus.load = 1'b1; bus.load_val = 4'd2; bus.mode = 1'b0;
        step();
        bus.load = 1'b0;
        check_out("pre_load", 4'd2, 1'b1, 1'b0);
`ifdef DOWNCOUNT_PRESCALE_EN
        repeat (3) step();
        check_out("pre_3en", 4'd2, 1'b1, 1'b0);
        bus.en = 1'b0;
        repeat (3) step();
        check_out("pre_paused", 4'd2, 1'b1, 1'b0);
        bus.en = 1'b1;
        step();
        check_out("pre_4en", 4'd1, 1'b1, 1'b0);
        repeat (3) step();
        check_out("pre_7en", 4'd1, 1'b1, 1'b0);
        step();
        check_out("pre_8en", 4'd0, 1'b0, 1'b1);
`else
        step();
        check_out("nopre_1", 4'd1, 1'b1, 1'b0);
        step();
        check_out("nopre_2", 4'd0, 1'b0, 1'b1);
`endif
        step();
        check_out("final_idle", 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
